// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bus between decode, the ALU issue stage and the EX stage.
// slave = the issue stage itself, master = the surrounding pipeline driving it.
interface alu_issue_stage_if #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 4,
  parameter int REG_W  = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_rs;
  logic [REG_W-1:0]  in_rt;
  logic [WORD_W-1:0] in_rs_data;
  logic [WORD_W-1:0] in_rt_data;
  logic [WORD_W-1:0] in_imm;
  logic              in_use_imm;
  logic [OP_W-1:0]   in_alu_op;
  logic              fwd_mem_en;
  logic [REG_W-1:0]  fwd_mem_reg;
  logic [WORD_W-1:0] fwd_mem_dat;
  logic              fwd_wb_en;
  logic [REG_W-1:0]  fwd_wb_reg;
  logic [WORD_W-1:0] fwd_wb_dat;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] port_a;
  logic [WORD_W-1:0] port_b;
  logic [OP_W-1:0]   alu_op;

  modport slave (
    input  flush, in_valid, in_rs, in_rt, in_rs_data, in_rt_data, in_imm,
           in_use_imm, in_alu_op, fwd_mem_en, fwd_mem_reg, fwd_mem_dat,
           fwd_wb_en, fwd_wb_reg, fwd_wb_dat, out_ready,
    output in_ready, out_valid, port_a, port_b, alu_op
  );

  modport master (
    output flush, in_valid, in_rs, in_rt, in_rs_data, in_rt_data, in_imm,
           in_use_imm, in_alu_op, fwd_mem_en, fwd_mem_reg, fwd_mem_dat,
           fwd_wb_en, fwd_wb_reg, fwd_wb_dat, out_ready,
    input  in_ready, out_valid, port_a, port_b, alu_op
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU operand issue stage: 2-entry skid buffer with EX/MEM and MEM/WB operand forwarding.
// Define ALU_ISSUE_FWD_EN to enable forwarding/snooping; otherwise operands are register-file values.
module alu_issue_stage #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 4,
  parameter int REG_W  = 5
) (
  input  logic CLK,
  input  logic RST,
  alu_issue_stage_if.slave bus
);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [OP_W-1:0]   aluop_t;
  typedef logic [REG_W-1:0]  idx_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic   fwd_mem_en, fwd_wb_en;
  idx_t   fwd_mem_reg, fwd_wb_reg;
  word_t  fwd_mem_dat, fwd_wb_dat;

  assign fwd_mem_en  = bus.fwd_mem_en;
  assign fwd_mem_reg = bus.fwd_mem_reg;
  assign fwd_mem_dat = bus.fwd_mem_dat;
  assign fwd_wb_en   = bus.fwd_wb_en;
  assign fwd_wb_reg  = bus.fwd_wb_reg;
  assign fwd_wb_dat  = bus.fwd_wb_dat;

  // $0 is never forwarded; the younger EX/MEM result wins over MEM/WB.
  function automatic word_t fwd_resolve(input idx_t idx, input word_t dat);
    fwd_resolve = dat;
    if (FWD_EN && idx != '0) begin
      if (fwd_mem_en && fwd_mem_reg == idx)
        fwd_resolve = fwd_mem_dat;
      else if (fwd_wb_en && fwd_wb_reg == idx)
        fwd_resolve = fwd_wb_dat;
    end
  endfunction

  state_t state, state_nxt;
  logic   in_ready_q;
  logic   acc;
  logic   ld_out_in, ld_out_skid, ld_skid;

  word_t  a_p1, b_p1;
  aluop_t op_p1;
  idx_t   rs_p1, rt_p1;
  logic   ui_p1;

  word_t  skid_a_p1, skid_b_p1;
  aluop_t skid_op_p1;
  idx_t   skid_rs_p1, skid_rt_p1;
  logic   skid_ui_p1;

  word_t  in_a_p0, in_b_p0;
  word_t  held_a, held_b, skid_a_rsv, skid_b_rsv;

  assign acc = bus.in_valid && in_ready_q;

  assign in_a_p0    = fwd_resolve(bus.in_rs, bus.in_rs_data);
  assign in_b_p0    = bus.in_use_imm ? bus.in_imm : fwd_resolve(bus.in_rt, bus.in_rt_data);
  assign held_a     = fwd_resolve(rs_p1, a_p1);
  assign held_b     = ui_p1 ? b_p1 : fwd_resolve(rt_p1, b_p1);
  assign skid_a_rsv = fwd_resolve(skid_rs_p1, skid_a_p1);
  assign skid_b_rsv = skid_ui_p1 ? skid_b_p1 : fwd_resolve(skid_rt_p1, skid_b_p1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != S_TWO);
    end
  end

  always_comb begin
    state_nxt   = state;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (state)
      S_EMPTY: begin
        if (acc) begin
          ld_out_in = 1'b1;
          state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (acc && bus.out_ready) begin
          ld_out_in = 1'b1;
        end else if (acc) begin
          ld_skid   = 1'b1;
          state_nxt = S_TWO;
        end else if (bus.out_ready) begin
          state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (bus.out_ready) begin
          ld_out_skid = 1'b1;
          state_nxt   = S_ONE;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
    // flush overrides every transfer into the stage
    if (bus.flush) begin
      state_nxt   = S_EMPTY;
      ld_out_in   = 1'b0;
      ld_out_skid = 1'b0;
      ld_skid     = 1'b0;
    end
  end

  // ---- output stage (p1): load from input or skid, otherwise snoop while held ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_p1  <= '0;
      b_p1  <= '0;
      op_p1 <= '0;
    end else if (!bus.flush) begin
      if (ld_out_in) begin
        a_p1  <= in_a_p0;
        b_p1  <= in_b_p0;
        op_p1 <= bus.in_alu_op;
        rs_p1 <= bus.in_rs;
        rt_p1 <= bus.in_rt;
        ui_p1 <= bus.in_use_imm;
      end else if (ld_out_skid) begin
        a_p1  <= skid_a_rsv;
        b_p1  <= skid_b_rsv;
        op_p1 <= skid_op_p1;
        rs_p1 <= skid_rs_p1;
        rt_p1 <= skid_rt_p1;
        ui_p1 <= skid_ui_p1;
      end else if (state != S_EMPTY && !bus.out_ready) begin
        a_p1 <= held_a;
        b_p1 <= held_b;
      end
    end
  end

  // ---- skid entry (p1): captured only when the output is stalled ----
  always_ff @(posedge CLK) begin
    if (ld_skid) begin
      skid_a_p1  <= in_a_p0;
      skid_b_p1  <= in_b_p0;
      skid_op_p1 <= bus.in_alu_op;
      skid_rs_p1 <= bus.in_rs;
      skid_rt_p1 <= bus.in_rt;
      skid_ui_p1 <= bus.in_use_imm;
    end else if (state == S_TWO && !bus.out_ready && !bus.flush) begin
      skid_a_p1 <= skid_a_rsv;
      skid_b_p1 <= skid_b_rsv;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state != S_EMPTY);
  assign bus.port_a    = a_p1;
  assign bus.port_b    = b_p1;
  assign bus.alu_op    = op_p1;

endmodule
